// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//
// Multi-cycle sequencer for the CPU DIV/DIVU datapath. A restoring radix-2
// divider produces one quotient bit per clock. While an operation is in
// flight, the core is frozen through 'stall'. The result drives HI (remainder)
// and LO (quotient).
//
// Parameters:
//   WIDTH      operand/result width; also the number of CALC iterations
//
// Ports:
//   clk_in     in   1      system clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   start      in   1      DIV/DIVU issue from decode; sampled only in IDLE
//   is_signed  in   1      1 = DIV (two's complement), 0 = DIVU
//   dividend   in   WIDTH  rs value, sampled with start
//   divisor    in   WIDTH  rt value, sampled with start
//   busy       out  1      registered; high while an operation is in flight
//   stall      out  1      combinational: busy | (start & state==IDLE)
//   done       out  1      registered one-cycle pulse; q/r valid
//   q          out  WIDTH  quotient (LO); holds until the next done
//   r          out  WIDTH  remainder (HI); holds until the next done
//   div_zero   out  1      only with `DIV_ZERO_FLAG_EN: pulses with done when
//                          the sampled divisor was zero
//
// Optional feature macro: DIV_ZERO_FLAG_EN
//
// Timing (start sampled at edge E0):
//   non-zero divisor : CALC on E1..E<WIDTH>, FIN hold, result/done after
//                      edge E0+WIDTH+2
//   zero divisor     : straight to FIN, result/done after edge E0+2
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
`ifdef DIV_ZERO_FLAG_EN
   ,
   output logic             div_zero
`endif
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Two's complement negation, modulo 2^WIDTH.
   function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   // Magnitude of a signed operand as an unsigned value. The most negative
   // value maps onto itself (0x80..0), which is exactly the magnitude when
   // read as unsigned.
   function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] res;
      res = $unsigned(v);
      if (v < 0)
         res = neg2c(res);
      return res;
   endfunction

   // Optional sign fix-up applied on the way out to q/r.
   function automatic logic [WIDTH-1:0] apply_sign(input logic             neg,
                                                   input logic [WIDTH-1:0] v);
      return neg ? neg2c(v) : v;
   endfunction

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   rem;       // one extra bit for the compare/subtract
   logic [WIDTH-1:0] quo;       // holds the dividend, shifted out as quotient fills in
   logic [WIDTH-1:0] dvs;       // divisor magnitude
   logic             qneg;
   logic             rneg;
   logic             fin_hold;  // first FIN cycle already spent
`ifdef DIV_ZERO_FLAG_EN
   logic             zero_op;   // current operation had a zero divisor
`endif

   // Operands viewed as signed for the DIV path.
   logic signed [WIDTH-1:0] dividend_s;
   logic signed [WIDTH-1:0] divisor_s;
   logic [WIDTH-1:0]        dividend_mag;
   logic [WIDTH-1:0]        divisor_mag;

   always_comb begin
      dividend_s   = $signed(dividend);
      divisor_s    = $signed(divisor);
      dividend_mag = is_signed ? abs_val(dividend_s) : dividend;
      divisor_mag  = is_signed ? abs_val(divisor_s)  : divisor;
   end

   // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
   logic [WIDTH:0]   rem_sh;
   logic             fits;
   logic [WIDTH:0]   rem_nx;
   logic [WIDTH-1:0] quo_nx;

   always_comb begin
      rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
      fits   = (rem_sh >= {1'b0, dvs});
      rem_nx = rem_sh;
      if (fits)
         rem_nx = rem_sh - {1'b0, dvs};
      quo_nx = {quo[WIDTH-2:0], fits};
   end

   // Stall covers the issuing cycle before busy has had a chance to rise.
   always_comb begin
      stall = busy | (start & (state == IDLE));
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         qneg     <= 1'b0;
         rneg     <= 1'b0;
         fin_hold <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         q        <= '0;
         r        <= '0;
`ifdef DIV_ZERO_FLAG_EN
         zero_op  <= 1'b0;
         div_zero <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
         div_zero <= 1'b0;
`endif
         case (state)
            // ---- IDLE: accept a new operation, latch operands ----
            IDLE: begin
               if (start) begin
                  busy     <= 1'b1;
                  cnt      <= '0;
                  fin_hold <= 1'b0;
                  if (divisor == '0) begin
                     // Architectural result for x/0: all ones and the raw
                     // dividend, with no sign fix-up in either mode.
                     quo     <= '1;
                     rem     <= {1'b0, dividend};
                     dvs     <= '0;
                     qneg    <= 1'b0;
                     rneg    <= 1'b0;
                     state   <= FIN;
`ifdef DIV_ZERO_FLAG_EN
                     zero_op <= 1'b1;
`endif
                  end else begin
                     quo     <= dividend_mag;
                     rem     <= '0;
                     dvs     <= divisor_mag;
                     qneg    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     rneg    <= is_signed & dividend[WIDTH-1];
                     state   <= CALC;
`ifdef DIV_ZERO_FLAG_EN
                     zero_op <= 1'b0;
`endif
                  end
               end
            end

            // ---- CALC: one quotient bit per edge ----
            CALC: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1))
                  state <= FIN;
            end

            // ---- FIN: one hold cycle, then publish result ----
            FIN: begin
               if (!fin_hold) begin
                  fin_hold <= 1'b1;
               end else begin
                  fin_hold <= 1'b0;
                  q        <= apply_sign(qneg, quo);
                  r        <= apply_sign(rneg, rem[WIDTH-1:0]);
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
`ifdef DIV_ZERO_FLAG_EN
                  div_zero <= zero_op;
`endif
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
